// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the register-file write-port logic.
package rv32_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   // One register-file write: enable, destination register and data.
   typedef struct packed {
      logic                  wen;
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } rf_wr_t;

endpackage

// File: rtl/rf_wport_fifo.sv
// Small holding FIFO for deferred LLU results.
// Entries can be killed in place by a younger pipeline write to the same rd.
module rf_wport_fifo #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic [rv32_pkg::REG_ADDR_W-1:0] push_rd,
   input  logic [XLEN-1:0]                 push_data,
   input  logic                            pop,
   input  logic                            kill_en,
   input  logic [rv32_pkg::REG_ADDR_W-1:0] kill_rd,
   output logic [$clog2(DEPTH+1)-1:0]      count,
   output logic [rv32_pkg::REG_ADDR_W-1:0] head_rd,
   output logic [XLEN-1:0]                 head_data,
   output logic                            head_live,
   output logic [31:0]                     live_rd_vec
);
   import rv32_pkg::*;

   localparam int PW = $clog2(DEPTH);

   logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
   logic [XLEN-1:0]       data_mem [DEPTH];
   logic [DEPTH-1:0]      live;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   // Payload storage; validity is tracked by the live bits, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]   <= push_rd;
         data_mem[wr_ptr] <= push_data;
      end
   end

   // Pointers, occupancy and live bits: kill first, then pop clears, then push sets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {PW{1'b0}};
         rd_ptr <= {PW{1'b0}};
         count  <= '0;
         live   <= {DEPTH{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && live[i] && (rd_mem[i] == kill_rd)) begin
               live[i] <= 1'b0;
            end
         end
         if (pop) begin
            live[rd_ptr] <= 1'b0;
            rd_ptr       <= rd_ptr + 1'b1;
         end
         if (push) begin
            live[wr_ptr] <= 1'b1;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_rd   = rd_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
   assign head_live = live[rd_ptr];

   // One-hot OR of the destination registers still waiting to be written.
   always_comb begin
      live_rd_vec = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i]) begin
            live_rd_vec[rd_mem[i]] = 1'b1;
         end else begin
            live_rd_vec = live_rd_vec;
         end
      end
   end

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: the pipeline writeback has priority,
// LLU results bypass when idle or wait in a FIFO, and an age counter forces
// a one-cycle pipeline stall so the FIFO head cannot starve.
module rf_wport_arb #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_wen,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_data,
   input  logic            llu_valid,
   input  logic [4:0]      llu_rd,
   input  logic [XLEN-1:0] llu_data,
   output logic            llu_ready,
   output logic            rf_wen,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            pipe_stall,
   output logic [31:0]     pend_rd_vec
);
   import rv32_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0]   count;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_data;
   logic            head_live;
   logic            fifo_empty;
   logic            llu_hs;
   logic            pipe_grant;
   logic            fifo_pop;
   logic            bypass;
   logic            push;
   logic            head_live_now;
   logic            stall_next;
   logic [AW-1:0]   age;
   logic [AW-1:0]   age_next;
   rf_wr_t          wr_next;
   rf_wr_t          wr_q;

   // A pop in the same cycle deliberately does not raise ready (no comb path).
   assign llu_ready  = (count < CW'(DEPTH));
   assign fifo_empty = (count == {CW{1'b0}});

   rf_wport_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_rd     (llu_rd),
      .push_data   (llu_data),
      .pop         (fifo_pop),
      .kill_en     (pipe_grant),
      .kill_rd     (pipe_rd),
      .count       (count),
      .head_rd     (head_rd),
      .head_data   (head_data),
      .head_live   (head_live),
      .live_rd_vec (pend_rd_vec)
   );

   // Grant selection: pipeline, else FIFO head, else LLU bypass; plus enqueue decision.
   always_comb begin
      wr_next    = '0;
      fifo_pop   = 1'b0;
      bypass     = 1'b0;
      llu_hs     = llu_valid && llu_ready;
      pipe_grant = pipe_wen && !pipe_stall && (pipe_rd != 5'd0);
      if (pipe_grant) begin
         wr_next.wen  = 1'b1;
         wr_next.addr = pipe_rd;
         wr_next.data = pipe_data;
      end else if (!fifo_empty) begin
         fifo_pop     = 1'b1;
         wr_next.wen  = head_live;
         wr_next.addr = head_rd;
         wr_next.data = head_data;
      end else if (llu_hs && (llu_rd != 5'd0)) begin
         bypass       = 1'b1;
         wr_next.wen  = 1'b1;
         wr_next.addr = llu_rd;
         wr_next.data = llu_data;
      end else begin
         wr_next = '0;
      end
      // An LLU result for the register the pipeline writes now is stale: drop it.
      push = llu_hs && (llu_rd != 5'd0) && !bypass &&
             !(pipe_grant && (llu_rd == pipe_rd));
   end

   // Age of the FIFO head; a head killed this cycle no longer ages.
   always_comb begin
      head_live_now = head_live && !(pipe_grant && (head_rd == pipe_rd));
      stall_next    = 1'b0;
      if (fifo_empty || fifo_pop) begin
         age_next = {AW{1'b0}};
      end else if (head_live_now) begin
         stall_next = (age == AW'(MAX_WAIT - 1));
         if (age != AW'(MAX_WAIT)) begin
            age_next = age + 1'b1;
         end else begin
            age_next = age;
         end
      end else begin
         age_next = age;
      end
   end

   // Registered write port, stall request and age state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q       <= '0;
         pipe_stall <= 1'b0;
         age        <= {AW{1'b0}};
      end else begin
         wr_q       <= wr_next;
         pipe_stall <= stall_next;
         age        <= age_next;
      end
   end

   assign rf_wen   = wr_q.wen;
   assign rf_waddr = wr_q.addr;
   assign rf_wdata = wr_q.data;

endmodule
